// File: rtl/mux8_scan_serializer_if.sv
// Handshake and serial-output bundle for the 8:1 mux select sequencer.
// master: upstream word source / downstream observer; slave: the serializer.
interface mux8_scan_serializer_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       S0;
  logic       S1;
  logic       S2;
  logic       Y;
  logic       y_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  modport master (
    output din, din_valid,
    input  din_ready, S0, S1, S2, Y, y_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, S0, S1, S2, Y, y_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/mux8_scan_serializer.sv
// Select sequencer / serializer for the 8:1 mux datapath.
// Latches an 8-bit word on a valid/ready transfer, then walks {S2,S1,S0}
// through 0..7 one step per clock, presenting the selected bit on Y with
// frame_start/frame_end strobes. GAP_CYCLES idle cycles follow each frame.
// Optional feature: define SCAN_PARITY_EN to append one even-parity bit
// cycle (select held at 7) to every frame.
module mux8_scan_serializer #(
  parameter int GAP_CYCLES = 0
) (
  input logic                   clk,
  input logic                   rst,
  mux8_scan_serializer_if.slave bus
);

`ifdef SCAN_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  // Back-to-back frames only when nothing has to follow bit 7.
  localparam bit         NO_BUBBLE = (GAP_CYCLES == 0) && !PAR_EN;
  localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t     state;
  logic [2:0] sel;
  logic [7:0] data;
  logic [3:0] gap_cnt;
  logic       y_q, yv_q, fs_q, fe_q;

  logic       sel_last;
  logic [2:0] sel_nxt;
  logic       din_ready;
  logic       xfer;

  assign sel_last = (sel == 3'd7);
  assign sel_nxt  = sel + 3'd1;

  // Ready is a pure function of state; held low while reset is asserted.
  assign din_ready = !rst &&
                     ((state == IDLE) || (NO_BUBBLE && (state == SHIFT) && sel_last));
  assign xfer      = bus.din_valid && din_ready;

  // Sequencer FSM with registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 3'd0;
      data    <= 8'd0;
      gap_cnt <= 4'd0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      y_q  <= 1'b0;
      yv_q <= 1'b0;
      fs_q <= 1'b0;
      fe_q <= 1'b0;
      if (xfer) begin
        // Accept from IDLE or from bit 7 of a no-bubble frame.
        data  <= bus.din;
        sel   <= 3'd0;
        y_q   <= bus.din[0];
        yv_q  <= 1'b1;
        fs_q  <= 1'b1;
        state <= SHIFT;
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            if (!sel_last) begin
              sel  <= sel_nxt;
              y_q  <= data[sel_nxt];
              yv_q <= 1'b1;
              fe_q <= !PAR_EN && (sel_nxt == 3'd7);
            end
`ifdef SCAN_PARITY_EN
            else begin
              y_q   <= ^data;
              yv_q  <= 1'b1;
              fe_q  <= 1'b1;
              state <= PARITY;
            end
`else
            else if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
`endif
          end
`ifdef SCAN_PARITY_EN
          PARITY: begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
`endif
          GAP: begin
            if (gap_cnt == 4'd0) state <= IDLE;
            else                 gap_cnt <= gap_cnt - 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.din_ready   = din_ready;
  assign bus.S0          = sel[0];
  assign bus.S1          = sel[1];
  assign bus.S2          = sel[2];
  assign bus.Y           = y_q;
  assign bus.y_valid     = yv_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_mux8_scan_serializer.sv
// Bench for mux8_scan_serializer: two instances (GAP_CYCLES 0 and 3) share
// one random stimulus stream; a frame-phase model predicts every output.
module tb_mux8_scan_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  int         tests = 0;
  int         fails = 0;
  bit         run = 1'b0;

`ifdef SCAN_PARITY_EN
  localparam int FL = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FL = 8;
  localparam bit PAR = 1'b0;
`endif

  always #5 clk = ~clk;

  mux8_scan_serializer_if if0 ();
  mux8_scan_serializer_if if1 ();

  assign if0.din = din;
  assign if0.din_valid = din_valid;
  assign if1.din = din;
  assign if1.din_valid = din_valid;

  mux8_scan_serializer #(.GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux8_scan_serializer #(.GAP_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Model: phase = cycles since the accepting edge (-1 when idle).
  // Phases 0..7 data bits, phase 8 parity (if enabled), then the gap.
  int         ph [2] = '{-1, -1};
  logic [7:0] word [2];

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit exp_ready(input int d);
    return !rst && ((ph[d] < 0) || (ph[d] == 7 && gap_of(d) == 0 && !PAR));
  endfunction

  task automatic chk(input string nm, input int d, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  bit r;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      r = exp_ready(d);
      if (rst) ph[d] = -1;
      else if (r && din_valid) begin
        word[d] = din;
        ph[d] = 0;
      end else if (ph[d] >= 0) begin
        ph[d]++;
        if (ph[d] >= FL + gap_of(d)) ph[d] = -1;
      end
    end
  end

  task automatic cmp(input int d, input logic rdy, input logic yv, input logic y,
                     input logic [2:0] s, input logic fs, input logic fe, input logic bz);
    int p;
    logic e_yv, e_y, e_fs, e_fe, e_bz;
    logic [2:0] e_s;
    bit chk_s;
    p = ph[d];
    e_yv = 0; e_y = 0; e_fs = 0; e_fe = 0; e_bz = 0; e_s = 3'd0; chk_s = 0;
    if (p >= 0 && p < 8) begin
      e_yv = 1; e_y = word[d][p]; e_s = 3'(p); e_fs = (p == 0);
      e_fe = (p == FL - 1); e_bz = 1; chk_s = 1;
    end else if (p >= 8) begin
      e_bz = 1; e_s = 3'd7; chk_s = 1;
      if (p < FL) begin
        e_yv = 1; e_y = ^word[d]; e_fe = 1;
      end
    end
    chk("din_ready", d, 24'(rdy), 24'(exp_ready(d)));
    chk("y_valid", d, 24'(yv), 24'(e_yv));
    chk("Y", d, 24'(y), 24'(e_y));
    chk("frame_start", d, 24'(fs), 24'(e_fs));
    chk("frame_end", d, 24'(fe), 24'(e_fe));
    chk("busy", d, 24'(bz), 24'(e_bz));
    if (chk_s) chk("select", d, 24'(s), 24'(e_s));
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (run) begin
      cmp(0, if0.din_ready, if0.y_valid, if0.Y, {if0.S2, if0.S1, if0.S0},
          if0.frame_start, if0.frame_end, if0.busy);
      cmp(1, if1.din_ready, if1.y_valid, if1.Y, {if1.S2, if1.S1, if1.S0},
          if1.frame_start, if1.frame_end, if1.busy);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [15:0] yb, yvb, fsb, feb, rdb;
  logic [23:0] selseq;
  int first_fs, second_fs;

  initial begin
    step();
    step();
    run = 1'b1;
    // Reset state, literal expectations.
    chk("rst_ready", 0, 24'(if0.din_ready), 24'd0);
    chk("rst_busy", 0, 24'(if0.busy), 24'd0);
    chk("rst_yvalid", 1, 24'(if1.y_valid), 24'd0);
    chk("rst_sel", 0, 24'({if0.S2, if0.S1, if0.S0}), 24'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", 0, 24'(if0.din_ready), 24'd1);

    // Single word 8'hAA.
    din = 8'hAA; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 8'h55;
    yb = '0; fsb = '0; feb = '0; selseq = '0;
    for (int k = 0; k < 9; k++) begin
      yb[k] = if0.Y; fsb[k] = if0.frame_start; feb[k] = if0.frame_end;
      if (k < 8) selseq[3*k +: 3] = {if0.S2, if0.S1, if0.S0};
      step();
    end
    chk("aa_stream", 0, 24'(yb[7:0]), 24'h0000AA);
    chk("aa_sel_seq", 0, selseq, 24'hFAC688);
    chk("aa_fstart", 0, 24'(fsb[8:0]), 24'h000001);
    chk("aa_fend", 0, 24'(feb[8:0]), PAR ? 24'h000100 : 24'h000080);
    repeat (14) step();
    chk("aa_idle_ready", 0, 24'(if0.din_ready), 24'd1);
    chk("aa_idle_ready", 1, 24'(if1.din_ready), 24'd1);

`ifndef SCAN_PARITY_EN
    // Back-to-back 8'h0F then 8'hF0, no bubble on the GAP_CYCLES=0 instance.
    din = 8'h0F; din_valid = 1'b1;
    step();
    yb = '0; yvb = '0; fsb = '0;
    for (int i = 0; i < 16; i++) begin
      yb[i] = if0.Y; yvb[i] = if0.y_valid; fsb[i] = if0.frame_start;
      if (i == 7) chk("b2b_ready_at7", 0, 24'(if0.din_ready), 24'd1);
      if (i == 6) din = 8'hF0;
      if (i == 15) din_valid = 1'b0;
      step();
    end
    chk("b2b_stream", 0, 24'(yb), 24'h00F00F);
    chk("b2b_yvalid", 0, 24'(yvb), 24'h00FFFF);
    chk("b2b_fstart", 0, 24'(fsb), 24'h000101);
`else
    // Parity frame for 8'h07.
    din = 8'h07; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    yb = '0; feb = '0; rdb = '0;
    for (int k = 0; k < 9; k++) begin
      yb[k] = if0.Y; feb[k] = if0.frame_end; rdb[k] = if0.din_ready;
      if (k == 8) chk("par_sel", 0, 24'({if0.S2, if0.S1, if0.S0}), 24'd7);
      step();
    end
    chk("par_stream", 0, 24'(yb[8:0]), 24'h000107);
    chk("par_fend", 0, 24'(feb[8:0]), 24'h000100);
    chk("par_ready_low", 0, 24'(rdb[8:0]), 24'd0);
`endif
    repeat (16) step();

    // Frame period on the GAP_CYCLES=3 instance with din toggling.
    first_fs = -1; second_fs = -1;
    din_valid = 1'b1;
    for (int i = 0; i < 60 && second_fs < 0; i++) begin
      if (if1.frame_start) begin
        if (first_fs < 0) first_fs = i;
        else second_fs = i;
      end
      din = 8'($urandom);
      step();
    end
    chk("gap_period", 1, 24'(second_fs - first_fs), 24'(PAR ? 13 : 12));
    din_valid = 1'b0;
    repeat (16) step();

    // Reset in the middle of a frame at select=4.
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (4) step();
    chk("mid_sel4", 0, 24'({if0.S2, if0.S1, if0.S0}), 24'd4);
    rst = 1'b1;
    step();
    chk("mid_rst_yvalid", 0, 24'(if0.y_valid), 24'd0);
    chk("mid_rst_fend", 0, 24'(if0.frame_end), 24'd0);
    chk("mid_rst_busy", 1, 24'(if1.busy), 24'd0);
    chk("mid_rst_sel", 0, 24'({if0.S2, if0.S1, if0.S0}), 24'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_ready", 0, 24'(if0.din_ready), 24'd1);

    // Random traffic; first stretch keeps din_valid high with din changing.
    for (int n = 0; n < 3000; n++) begin
      din = 8'($urandom);
      din_valid = (n < 500) || ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; din_valid = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux8_scan_serializer.md
Name: mux8_scan_serializer

Overview:
Upstream select sequencer and serializer for the 8:1 mux datapath.
- Accepts an 8-bit parallel word over a valid/ready handshake and latches it.
- Steps the 3-bit select S2..S0 through 0..7, one value per clock, and presents the selected bit on Y with framing strobes.
- Replaces hand-driven select stimulus with a clocked, handshaked source.

Parameters:
GAP_CYCLES, 0, idle cycles forced after each frame before the next word is accepted (0..15)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
din  input  8  parallel data word; bit k is serialized at select value k
din_valid  input  1  din holds a word for transfer
din_ready  output  1  block can accept a word this cycle
S0  output  1  select bit 0 (LSB)
S1  output  1  select bit 1
S2  output  1  select bit 2 (MSB)
Y  output  1  serial data bit, equal to latched word bit {S2,S1,S0}
y_valid  output  1  Y/S2..S0 carry a live frame bit
frame_start  output  1  high on first bit cycle of a frame
frame_end  output  1  high on last cycle of a frame
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst). All state changes on rising clk.
- Reset values: state IDLE; {S2,S1,S0}=000; Y=0; y_valid=0; frame_start=0; frame_end=0; busy=0; data register=0; gap counter=0.
- din_ready is forced 0 in any cycle where rst=1.
- States: IDLE, SHIFT, PARITY (only with the optional feature), GAP.
- Transfer rule: a transfer occurs when din_valid=1 and din_ready=1 in the same cycle.
- din_ready is combinational from state:
  - 1 in IDLE.
  - 1 in SHIFT at select=7 only when GAP_CYCLES=0 and the parity feature is off.
  - 0 otherwise.
- IDLE: on transfer, latch din, go to SHIFT with select=0. Without a transfer, stay in IDLE with y_valid=0.
- SHIFT:
  - Outputs registered; on select=k: y_valid=1, Y=data[k].
  - frame_start=1 only at k=0; select increments by 1 each cycle.
  - At k=7: frame_end=1, unless parity is enabled.
  - Exit at k=7:
    - parity enabled: go to PARITY.
    - else GAP_CYCLES>0: go to GAP.
    - else with a transfer in this cycle: go back to SHIFT k=0 with the new word (8-cycle frame period, no bubble).
    - else go to IDLE.
- GAP: y_valid=0, select held at 7, Y=0. After GAP_CYCLES cycles, go to IDLE.
- Latency: first bit (k=0) appears the cycle after the accepting edge. A frame occupies exactly 8 cycles, or 9 with parity.
- din and din_valid are ignored outside ready cycles. The latched word is immune to din changes mid-frame.
- Reset mid-frame: frame aborts immediately with no frame_end; next cycle is IDLE with reset values.
- When y_valid=0, Y is driven to 0 and the select outputs are don't-care but stable.

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined:
  - After k=7, one PARITY cycle: y_valid=1, select held at 111, Y = XOR of all 8 latched bits (even parity), frame_end=1 on this cycle instead of k=7.
  - din_ready is never asserted in SHIFT.
  - After PARITY: go to GAP if GAP_CYCLES>0, else IDLE.
- Undefined: no PARITY state or logic; frames are 8 cycles.

Test Plan:
- Reset then din=8'hAA, din_valid=1 one cycle: next 8 cycles show select 0..7, Y=0,1,0,1,0,1,0,1, frame_start on cycle 1 only, frame_end on cycle 8, then IDLE with din_ready=1.
- Back-to-back, GAP_CYCLES=0: din_valid held high with 8'h0F then 8'hF0. Second word is accepted at select=7 of the first. Y stream is 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1 with no idle cycle, and frame_start is asserted every 8 cycles.
- GAP_CYCLES=3, din_valid held high: y_valid low for exactly 3 cycles between frames, then din_ready high in IDLE. Frame period is 12 cycles (8 SHIFT + 3 GAP + 1 IDLE accept).
- Reset asserted at select=4 of a frame with din=8'hFF: next cycle all outputs are at reset values, no frame_end is seen, and a new word is accepted normally afterwards.
- din toggled every cycle while busy, din_valid held high during SHIFT: serialized bits match the word latched at acceptance only, and no extra transfers occur.
- SCAN_PARITY_EN defined, din=8'h07: Y=1,1,1,0,0,0,0,0 then a parity cycle with Y=1 and select=111. frame_end is asserted on cycle 9 only, and din_ready stays 0 throughout SHIFT.
